// File: rtl/core_state_sequencer_pkg.sv
// Shared state encoding for the core sequencer.
// The debug and trace logic also uses this encoding.
package core_state_defs;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] FETCH_REQ = 4'd0;
  localparam logic [STATE_W-1:0] FETCH_RCV = 4'd1;
  localparam logic [STATE_W-1:0] DECODE    = 4'd2;
  localparam logic [STATE_W-1:0] SETUP     = 4'd3;
  localparam logic [STATE_W-1:0] EXECUTE   = 4'd4;
  localparam logic [STATE_W-1:0] MEM_READ  = 4'd5;
  localparam logic [STATE_W-1:0] WRITEBACK = 4'd6;
  localparam logic [STATE_W-1:0] HALT      = 4'd7;
  localparam logic [STATE_W-1:0] FAULT     = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH_REQ = FETCH_REQ,
    ST_FETCH_RCV = FETCH_RCV,
    ST_DECODE    = DECODE,
    ST_SETUP     = SETUP,
    ST_EXECUTE   = EXECUTE,
    ST_MEM_READ  = MEM_READ,
    ST_WRITEBACK = WRITEBACK,
    ST_HALT      = HALT,
    ST_FAULT     = FAULT
  } state_e;

endpackage

// File: rtl/core_state_sequencer_if.sv
// Handshake and phase bundle between the sequencer and the rest of the core.
// The master side is the sequencer. The slave side is the memory and frame logic.
interface core_state_sequencer_if;

  logic instr_memReady;
  logic data_memReady;
  logic frame_load;
  logic frame_store;
  logic halt_request;
  logic resume;

  logic fetch_RequestState;
  logic fetch_ReceiveState;
  logic decodeState;
  logic setupState;
  logic executeState;
  logic memReadState;
  logic writebackState;
  logic instr_readRequest;
  logic data_readRequest;
  logic data_writeRequest;
  logic halted;
  logic fault;

  modport master (
    input  instr_memReady, data_memReady, frame_load, frame_store,
           halt_request, resume,
    output fetch_RequestState, fetch_ReceiveState, decodeState, setupState,
           executeState, memReadState, writebackState,
           instr_readRequest, data_readRequest, data_writeRequest,
           halted, fault
  );

  modport slave (
    output instr_memReady, data_memReady, frame_load, frame_store,
           halt_request, resume,
    input  fetch_RequestState, fetch_ReceiveState, decodeState, setupState,
           executeState, memReadState, writebackState,
           instr_readRequest, data_readRequest, data_writeRequest,
           halted, fault
  );

endinterface

// File: rtl/core_state_sequencer_mem_wait_timer.sv
// Memory-wait counter with its limit compare.
// expired is raised in the last permitted wait cycle when the ready input is still low.
// A LIMIT of 0 disables the compare.
module mem_wait_timer #(
  parameter int LIMIT = 255,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Count the waiting cycles. A state change clears the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  generate
    if (LIMIT == 0) begin : g_no_limit
      assign expired = 1'b0;
    end else begin : g_limit
      assign expired = count_en && (cnt_q == WIDTH'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/core_state_sequencer.sv
// Main control FSM of the core. It generates the one-hot phase flags and the memory strobes.
// Optional macro CORE_STATE_SEQ_PERF_COUNTERS_EN adds the cycle_count and retired_count outputs.
module core_state_sequencer
  import core_state_defs::*;
#(
  parameter int MEM_TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH      = 8,
  parameter int PERF_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  core_state_sequencer_if.master bus
`ifdef CORE_STATE_SEQ_PERF_COUNTERS_EN
  ,
  output logic [PERF_WIDTH-1:0] cycle_count,
  output logic [PERF_WIDTH-1:0] retired_count
`endif
);

  state_e state_q, state_d;
  logic   store_pend;
  logic   wait_en;
  logic   expired;

  // A load wins over a store, so a store is pending only when no load is flagged.
  assign store_pend = bus.frame_store & ~bus.frame_load;

  // A cycle counts as waiting only while the sequencer waits on memory and ready is low.
  always_comb begin
    wait_en = 1'b0;
    case (state_q)
      ST_FETCH_REQ: wait_en = ~bus.instr_memReady;
      ST_MEM_READ:  wait_en = ~bus.data_memReady;
      ST_WRITEBACK: wait_en = store_pend & ~bus.data_memReady;
      default:      wait_en = 1'b0;
    endcase
  end

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT_CYCLES),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .count_en (wait_en),
    .expired  (expired)
  );

  // Next-state logic. When ready arrives in the limit cycle, ready wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH_REQ: begin
        if (bus.instr_memReady) state_d = ST_FETCH_RCV;
        else if (expired)       state_d = ST_FAULT;
      end
      ST_FETCH_RCV: state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = bus.frame_load ? ST_MEM_READ : ST_WRITEBACK;
      ST_MEM_READ: begin
        if (bus.data_memReady) state_d = ST_WRITEBACK;
        else if (expired)      state_d = ST_FAULT;
      end
      ST_WRITEBACK: begin
        if (!store_pend || bus.data_memReady)
          state_d = bus.halt_request ? ST_HALT : ST_FETCH_REQ;
        else if (expired)
          state_d = ST_FAULT;
      end
      ST_HALT:  if (bus.resume) state_d = ST_FETCH_REQ;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH_REQ;
    endcase
  end

  // State register. Reset clears it asynchronously, so the strobes drop at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH_REQ;
    else       state_q <= state_d;
  end

  // Decode the outputs from the state register. Only the write strobe also uses the frame flags.
  always_comb begin
    bus.fetch_RequestState = (state_q == ST_FETCH_REQ);
    bus.fetch_ReceiveState = (state_q == ST_FETCH_RCV);
    bus.decodeState        = (state_q == ST_DECODE);
    bus.setupState         = (state_q == ST_SETUP);
    bus.executeState       = (state_q == ST_EXECUTE);
    bus.memReadState       = (state_q == ST_MEM_READ);
    bus.writebackState     = (state_q == ST_WRITEBACK);
    bus.instr_readRequest  = (state_q == ST_FETCH_REQ);
    bus.data_readRequest   = (state_q == ST_MEM_READ);
    bus.data_writeRequest  = (state_q == ST_WRITEBACK) & store_pend;
    bus.halted             = (state_q == ST_HALT);
    bus.fault              = (state_q == ST_FAULT);
  end

`ifdef CORE_STATE_SEQ_PERF_COUNTERS_EN
  logic [PERF_WIDTH-1:0] cycle_q, retired_q;
  logic                  wb_exit;

  assign wb_exit = (state_q == ST_WRITEBACK) &&
                   ((state_d == ST_FETCH_REQ) || (state_d == ST_HALT));

  // The performance counters stop in HALT and FAULT and wrap when they overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if (state_q != ST_HALT && state_q != ST_FAULT) cycle_q <= cycle_q + 1'b1;
      if (wb_exit) retired_q <= retired_q + 1'b1;
    end
  end

  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_core_state_sequencer.sv
// Self-checking bench for core_state_sequencer, built with a 4-cycle memory timeout.
module tb_core_state_sequencer;

  localparam int S_FR = 0, S_RC = 1, S_DE = 2, S_SU = 3, S_EX = 4,
                 S_MR = 5, S_WB = 6, S_HALT = 7, S_FAULT = 8;

  typedef struct {
    logic imr, dmr, fl, fs, hr, rs;
    int   st;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  step_t       stim_q[$];
  logic [11:0] exp_q[$];

  core_state_sequencer_if bus ();

`ifdef CORE_STATE_SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count, retired_count;
`endif

  core_state_sequencer #(
    .MEM_TIMEOUT_CYCLES (4),
    .TIMEOUT_WIDTH      (8),
    .PERF_WIDTH         (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CORE_STATE_SEQ_PERF_COUNTERS_EN
    ,
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output vector: {7 phase flags, ireq, drd, dwr, halted, fault}.
  function automatic logic [11:0] outv(int st, logic fl, logic fs);
    logic [6:0] ph;
    ph = (st < 7) ? (7'b1000000 >> st) : 7'b0;
    return {ph, st == S_FR, st == S_MR, (st == S_WB) && fs && !fl,
            st == S_HALT, st == S_FAULT};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.fetch_RequestState, bus.fetch_ReceiveState, bus.decodeState,
            bus.setupState, bus.executeState, bus.memReadState, bus.writebackState,
            bus.instr_readRequest, bus.data_readRequest, bus.data_writeRequest,
            bus.halted, bus.fault};
  endfunction

  task automatic add(logic imr, logic dmr, logic fl, logic fs, logic hr, logic rs, int st);
    step_t s;
    s.imr = imr; s.dmr = dmr; s.fl = fl; s.fs = fs; s.hr = hr; s.rs = rs; s.st = st;
    stim_q.push_back(s);
  endtask

  task automatic apply(step_t s);
    bus.instr_memReady = s.imr;
    bus.data_memReady  = s.dmr;
    bus.frame_load     = s.fl;
    bus.frame_store    = s.fs;
    bus.halt_request   = s.hr;
    bus.resume         = s.rs;
  endtask

  task automatic do_reset();
    bus.instr_memReady = 1'b0; bus.data_memReady = 1'b0;
    bus.frame_load = 1'b0; bus.frame_store = 1'b0;
    bus.halt_request = 1'b0; bus.resume = 1'b0;
    reset = 1'b1;
    #2;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e, got;
    @(posedge clk); #3;
    reset = 1'b1;
    bus.instr_memReady = 1'b1;
    #1;
    exp_q.push_back(outv(S_FR, 1'b0, 1'b0));
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_async: got %b want %b", got, e); end
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(outv(S_FR, 1'b0, 1'b0));
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_held: got %b want %b", got, e); end
  endtask

  task automatic test_basic();
    step_t s; logic [11:0] e, got; int k = 0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add(1,0,0,0,0,0,S_FR); add(1,0,0,0,0,0,S_RC); add(1,0,0,0,0,0,S_DE);
      add(1,0,0,0,0,0,S_SU); add(1,0,0,0,0,0,S_EX); add(1,0,0,0,0,0,S_WB);
    end
    add(1,0,0,0,0,0,S_FR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL basic step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_wait();
    step_t s; logic [11:0] e, got; int k = 0;
    do_reset();
    add(0,0,0,0,0,0,S_FR); add(0,0,0,0,0,0,S_FR); add(0,0,0,0,0,0,S_FR);
    add(1,0,0,0,0,0,S_FR); add(0,0,0,0,0,0,S_RC); add(0,0,0,0,0,0,S_DE);
    add(0,0,0,0,0,0,S_SU); add(0,0,0,0,0,0,S_EX); add(0,0,0,0,0,0,S_WB);
    add(1,0,0,0,0,0,S_FR); add(1,0,0,0,0,0,S_RC);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL fetch_wait step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    step_t s; logic [11:0] e, got; int k = 0;
    do_reset();
    add(1,0,1,0,0,0,S_FR); add(1,0,1,0,0,0,S_RC); add(1,0,1,0,0,0,S_DE);
    add(1,0,1,0,0,0,S_SU); add(1,0,1,0,0,0,S_EX); add(1,0,1,0,0,0,S_MR);
    add(1,0,1,0,0,0,S_MR); add(1,1,1,0,0,0,S_MR); add(1,0,1,0,0,0,S_WB);
    // A load with the store flag also set takes MEM_READ and issues no store.
    add(1,0,1,1,0,0,S_FR); add(1,0,1,1,0,0,S_RC); add(1,0,1,1,0,0,S_DE);
    add(1,0,1,1,0,0,S_SU); add(1,0,1,1,0,0,S_EX); add(1,1,1,1,0,0,S_MR);
    add(1,0,1,1,0,0,S_WB); add(1,0,1,1,0,0,S_FR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL load step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    step_t s; logic [11:0] e, got; int k = 0;
    do_reset();
    add(1,0,0,1,0,0,S_FR); add(1,0,0,1,0,0,S_RC); add(1,0,0,1,0,0,S_DE);
    add(1,0,0,1,0,0,S_SU); add(1,0,0,1,0,0,S_EX); add(1,0,0,1,0,0,S_WB);
    add(1,0,0,1,0,0,S_WB); add(1,1,0,1,0,0,S_WB); add(1,0,0,1,0,0,S_FR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL store step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s; logic [11:0] e, got; int k = 0;
    do_reset();
    add(1,0,1,0,0,0,S_FR); add(1,0,1,0,0,0,S_RC); add(1,0,1,0,0,0,S_DE);
    add(1,0,1,0,0,0,S_SU); add(1,0,1,0,0,0,S_EX);
    for (int i = 0; i < 4; i++) add(1,0,1,0,0,0,S_MR);
    add(1,1,1,0,1,1,S_FAULT); add(1,1,1,0,0,1,S_FAULT); add(1,0,1,0,0,0,S_FAULT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL timeout step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
    // Ready in the limit cycle wins over the timeout.
    do_reset(); k = 0;
    add(1,0,1,0,0,0,S_FR); add(1,0,1,0,0,0,S_RC); add(1,0,1,0,0,0,S_DE);
    add(1,0,1,0,0,0,S_SU); add(1,0,1,0,0,0,S_EX);
    for (int i = 0; i < 3; i++) add(1,0,1,0,0,0,S_MR);
    add(1,1,1,0,0,0,S_MR); add(1,0,1,0,0,0,S_WB); add(1,0,1,0,0,0,S_FR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL ready_at_limit step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
    // Reset in the middle of a load.
    do_reset(); k = 0;
    add(1,0,1,0,0,0,S_FR); add(1,0,1,0,0,0,S_RC); add(1,0,1,0,0,0,S_DE);
    add(1,0,1,0,0,0,S_SU); add(1,0,1,0,0,0,S_EX); add(1,0,1,0,0,0,S_MR);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL mid_load step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
    #2; reset = 1'b1; #1;
    exp_q.push_back(outv(S_FR, 1'b1, 1'b0));
    got = obs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL mid_load_reset: got %b want %b", got, e); end
  endtask

  task automatic test_halt();
    step_t s; logic [11:0] e, got; int k = 0;
    do_reset();
    add(1,0,0,0,0,0,S_FR); add(1,0,0,0,0,0,S_RC); add(1,0,0,0,0,1,S_DE);
    add(1,0,0,0,0,0,S_SU); add(1,0,0,0,1,0,S_EX); add(1,0,0,0,1,0,S_WB);
    add(1,0,0,0,1,0,S_HALT); add(1,0,0,0,1,0,S_HALT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL halt step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
`ifdef CORE_STATE_SEQ_PERF_COUNTERS_EN
    n_cmp++;
    if (retired_count !== 32'd1) begin n_bad++; $display("FAIL retired_count: got %0d want 1", retired_count); end
    n_cmp++;
    if (cycle_count !== 32'd6) begin n_bad++; $display("FAIL cycle_count_halted: got %0d want 6", cycle_count); end
`endif
    add(1,0,0,0,0,0,S_HALT); add(1,0,0,0,0,1,S_HALT); add(1,0,0,0,0,0,S_FR);
    add(1,0,0,0,0,0,S_RC);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      exp_q.push_back(outv(s.st, s.fl, s.fs));
      @(negedge clk);
      got = obs(); e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL resume step %0d: got %b want %b", k, got, e); end
      k++; @(posedge clk); #1;
    end
`ifdef CORE_STATE_SEQ_PERF_COUNTERS_EN
    n_cmp++;
    if (cycle_count !== 32'd8) begin n_bad++; $display("FAIL cycle_count_resumed: got %0d want 8", cycle_count); end
`endif
  endtask

  initial begin
    bus.instr_memReady = 1'b0; bus.data_memReady = 1'b0;
    bus.frame_load = 1'b0; bus.frame_store = 1'b0;
    bus.halt_request = 1'b0; bus.resume = 1'b0;
    test_reset();
    test_basic();
    test_fetch_wait();
    test_load();
    test_store();
    test_timeout();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_state_sequencer.md
Name: core_state_sequencer

Overview:
- Main control FSM of the core. Generates the one-hot phase signals (fetch_RequestState … writebackState) that the frame write-enable logic consumes.
- Handshakes with instruction and data memory, and inserts the memory-read phase only for loads.
- Supports halt/resume and a memory-wait timeout fault.

Parameters:
MEM_TIMEOUT_CYCLES, 255, max cycles any memory wait may last before FAULT; 0 disables timeout
TIMEOUT_WIDTH, 8, width of wait counter; must satisfy 2^TIMEOUT_WIDTH > MEM_TIMEOUT_CYCLES
PERF_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_memReady  input  1  instruction memory has valid data this cycle
data_memReady  input  1  data memory completed read/write this cycle
frame_load  input  1  latched load flag of current instruction (valid from SETUP onward)
frame_store  input  1  latched store flag of current instruction (valid from SETUP onward)
halt_request  input  1  stop after current instruction retires
resume  input  1  leave HALT
fetch_RequestState  output  1  phase flag
fetch_ReceiveState  output  1  phase flag
decodeState  output  1  phase flag
setupState  output  1  phase flag
executeState  output  1  phase flag
memReadState  output  1  phase flag
writebackState  output  1  phase flag
instr_readRequest  output  1  instruction fetch strobe
data_readRequest  output  1  data read strobe
data_writeRequest  output  1  data write strobe
halted  output  1  in HALT
fault  output  1  in FAULT (sticky)

Behaviour:
- State register with states FETCH_REQ, FETCH_RCV, DECODE, SETUP, EXECUTE, MEM_READ, WRITEBACK, HALT, FAULT.
- All outputs are decoded combinationally from the state register only, except data_writeRequest. Phase flags are one-hot; all seven are 0 in HALT and FAULT.
- Reset (asynchronous): state=FETCH_REQ and wait counter=0. Immediately after reset: fetch_RequestState=1, instr_readRequest=1, all other outputs 0.
- State transitions:
  - FETCH_REQ: held while instr_memReady=0; on instr_memReady=1 → FETCH_RCV. FETCH_RCV therefore lasts exactly 1 cycle, so the CIR is written once with valid data.
  - FETCH_RCV → DECODE → SETUP → EXECUTE: 1 cycle each, unconditional.
  - EXECUTE: frame_load=1 → MEM_READ; otherwise → WRITEBACK. If frame_load and frame_store are both 1, load wins and no store is issued.
  - MEM_READ: data_readRequest=1. Held until data_memReady=1, then → WRITEBACK.
  - WRITEBACK: data_writeRequest = frame_store & ~frame_load.
    - If a store is pending, held until data_memReady=1.
    - Otherwise 1 cycle.
    - On exit: halt_request=1 → HALT, else → FETCH_REQ.
  - HALT: resume=1 → FETCH_REQ. halt_request is ignored in HALT; resume takes effect only in HALT.
  - FAULT: terminal; only reset exits.
- Minimum instruction latency: 6 cycles for a non-memory instruction with instr_memReady already 1 (FETCH_REQ through WRITEBACK, one cycle each). A load adds at least 1 cycle for MEM_READ.
- halt_request asserted in any other state is sampled only at WRITEBACK exit. It is not latched, so the requester must hold it.
- Wait counter:
  - Increments each cycle spent in FETCH_REQ, MEM_READ or store-WRITEBACK while the ready input is 0.
  - Clears on every state change.
  - When counter = MEM_TIMEOUT_CYCLES-1 and ready is still 0 → FAULT.
  - If ready arrives in the limit cycle, ready wins and the normal transition occurs.
  - MEM_TIMEOUT_CYCLES=0: counter is never compared and FAULT is unreachable.
- Reset mid-operation: outstanding memory strobes deassert asynchronously; no partial state is retained.

Optional Feature:
- Macro: CORE_STATE_SEQ_PERF_COUNTERS_EN.
- Defined: adds output ports cycle_count[PERF_WIDTH-1:0] and retired_count[PERF_WIDTH-1:0].
  - cycle_count increments every cycle except in HALT and FAULT.
  - retired_count increments on each WRITEBACK exit.
  - Both counters reset to 0 and wrap modulo 2^PERF_WIDTH.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Shared include/package core_state_defs: state encoding localparams (FETCH_REQ=0 … FAULT=8, 4-bit) and STATE_W=4, also used by debug/trace logic.
- One sub-module: mem_wait_timer, containing the wait counter plus its limit compare. Inputs: clear, count_en. Output: expired.

Test Plan:
- Reset with instr_memReady=1, no load/store → phases follow FETCH_REQ…WRITEBACK in 6 cycles, then repeat; exactly one phase flag high each cycle.
- instr_memReady held low 3 cycles → FETCH_REQ lasts 4 cycles; FETCH_RCV lasts exactly 1.
- Load with data_memReady arriving 2 cycles after entering MEM_READ → MEM_READ lasts 3 cycles, data_readRequest=1 throughout, then WRITEBACK.
- Store with data_memReady low 2 cycles → WRITEBACK lasts 3 cycles, data_writeRequest=1 only then; frame_load=frame_store=1 → MEM_READ taken, data_writeRequest never 1.
- MEM_TIMEOUT_CYCLES=4, data_memReady never asserted in MEM_READ → FAULT after 4 cycles, fault=1, all phases 0; ready in 4th cycle instead → WRITEBACK. Reset mid-load → FETCH_REQ immediately, data_readRequest=0.
- halt_request asserted during EXECUTE and held → HALT after WRITEBACK, halted=1; resume pulse → FETCH_REQ next cycle. With CORE_STATE_SEQ_PERF_COUNTERS_EN: retired_count=1, and cycle_count does not advance while halted.
